// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC scan controller.
package adc_pkg;

  localparam int unsigned NCH_ADC      = 8;
  localparam int unsigned NBITS_ADC    = 12;
  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned ADDR_MSB_BIT = 2;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} adc_state_t;

  typedef logic [NBITS_ADC-1:0] adc_word_t;

  // Lowest enabled channel strictly after cur, wrapping; a lone bit at cur selects cur again.
  function automatic logic [2:0] next_channel(input logic [2:0]         cur,
                                              input logic [NCH_ADC-1:0] mask);
    logic [2:0] c;
    next_channel = cur;
    for (int i = NCH_ADC; i >= 1; i--) begin
      c = cur + 3'(i);
      if (mask[c]) next_channel = c;
    end
  endfunction

endpackage

// File: rtl/adc_sclk_tick.sv
// Half-period divider: pulses tick_o every CLK_DIV cycles, held at zero while clear_i is high.
module adc_sclk_tick #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = !clear_i && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for an 8-channel 12-bit serial ADC with a per-channel result bank.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned NCH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NCH-1:0]       ch_mask,
  output logic                 ADC_CS_N,
  output logic                 ADC_SCLK,
  output logic                 ADC_SADDR,
  input  logic                 ADC_SDAT,
  output logic [NBITS_ADC-1:0] sample,
  output logic [2:0]           sample_ch,
  output logic                 sample_valid,
  input  logic [2:0]           rd_ch,
  output logic [NBITS_ADC-1:0] rd_data,
  output logic                 busy
);

  adc_state_t state_q;
  logic [3:0] k_q;
  logic       phase_q;
  logic [2:0] next_ch_q, cur_ch_q, prev_ch_q;
  logic       first_q;
  adc_word_t  shreg_q;
  logic       cs_n_q, sclk_q, saddr_q;
  adc_word_t  sample_q;
  logic [2:0] sample_ch_q;
  logic       valid_q;
  adc_word_t  bank_q [NCH];

  logic       tick;
  logic [1:0] addr_idx;
  logic       addr_bit;

  adc_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  // Bits k=2..4 carry the channel address MSB first; all other bits send zero.
  always_comb begin
    addr_idx = 2'(ADDR_MSB_BIT + 2) - k_q[1:0];
    addr_bit = 1'b0;
    if (k_q >= 4'(ADDR_MSB_BIT) && k_q <= 4'(ADDR_MSB_BIT + 2)) begin
      addr_bit = next_ch_q[addr_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      phase_q     <= 1'b0;
      next_ch_q   <= '0;
      cur_ch_q    <= 3'd7;
      prev_ch_q   <= '0;
      first_q     <= 1'b1;
      shreg_q     <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      saddr_q     <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) bank_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable && (|ch_mask)) begin
            next_ch_q <= next_channel(cur_ch_q, ch_mask);
            cs_n_q    <= 1'b0;
            state_q   <= SETUP;
          end else begin
            // Any idle gap breaks the address pipeline, so the next frame is a dummy.
            first_q <= 1'b1;
          end
        end
        SETUP: begin
          if (tick) begin
            k_q     <= '0;
            phase_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!phase_q) begin
              sclk_q  <= 1'b0;
              saddr_q <= addr_bit;
              phase_q <= 1'b1;
            end else begin
              // Leading zero bits fall off the top of the 12-bit shift register.
              sclk_q  <= 1'b1;
              shreg_q <= {shreg_q[NBITS_ADC-2:0], ADC_SDAT};
              phase_q <= 1'b0;
              if (k_q == 4'(FRAME_BITS - 1)) begin
                cs_n_q  <= 1'b1;
                saddr_q <= 1'b0;
                state_q <= HOLD;
              end else begin
                k_q <= k_q + 4'd1;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (!first_q) begin
              bank_q[prev_ch_q] <= shreg_q;
              sample_q          <= shreg_q;
              sample_ch_q       <= prev_ch_q;
              valid_q           <= 1'b1;
            end
            prev_ch_q <= next_ch_q;
            cur_ch_q  <= next_ch_q;
            first_q   <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ADC_CS_N     = cs_n_q;
  assign ADC_SCLK     = sclk_q;
  assign ADC_SADDR    = saddr_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = valid_q;
  assign rd_data      = bank_q[rd_ch];
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed and randomized bench for adc_scan_ctrl with a behavioural serial ADC and channel model.
module tb_adc_scan_ctrl;

  localparam int unsigned ClkDiv = 2;

  typedef struct {
    logic [7:0]  mask;
    bit          fresh;
    int          falls;
    int          minlow;
    int          maxlow;
    int          cslen;
    int          setup;
    logic [15:0] pat;
  } frame_t;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] val;
    int          cyc;
  } strobe_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        ADC_CS_N, ADC_SCLK, ADC_SADDR;
  logic        ADC_SDAT = 1'b0;
  logic [11:0] sample;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic [2:0]  rd_ch = 3'd0;
  logic [11:0] rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  adc_scan_ctrl #(
    .CLK_DIV (ClkDiv),
    .NCH     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .ADC_CS_N     (ADC_CS_N),
    .ADC_SCLK     (ADC_SCLK),
    .ADC_SADDR    (ADC_SADDR),
    .ADC_SDAT     (ADC_SDAT),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .rd_ch        (rd_ch),
    .rd_data      (rd_data),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [11:0] exp_val(input logic [2:0] ch);
    return 12'(int'(ch) * 256 + 'hAB);
  endfunction

  function automatic int nextch(input int cur, input logic [7:0] m);
    for (int i = 1; i <= 8; i++) begin
      int c;
      c = (cur + i) % 8;
      if (m[c]) return c;
    end
    return cur;
  endfunction

  int          m_cur = 7;
  int          m_prev = 0;
  logic [11:0] m_bank [8];

  // ---------------- ADC model and bus monitor ----------------
  int          cyc = 0, frames_done = 0, starts = 0, sclk_bad = 0, mon_falls = 0, lowlen = 0;
  int          fresh_req = 0, fresh_seen = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [15:0] adc_word = '0;
  logic [2:0]  addr_sh = '0, data_addr = '0;
  frame_t      cur_f;
  frame_t      frames[$];
  strobe_t     strobes[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sample_valid === 1'b1) strobes.push_back('{ch: sample_ch, val: sample, cyc: cyc});
    if (prev_cs === 1'b1 && ADC_CS_N === 1'b0) begin
      starts = starts + 1;
      cur_f = '{mask: ch_mask, fresh: (fresh_req != fresh_seen), falls: 0, minlow: 1000,
                maxlow: 0, cslen: 0, setup: 0, pat: '0};
      fresh_seen = fresh_req;
      mon_falls  = 0;
      addr_sh    = '0;
      adc_word   = {4'h0, exp_val(data_addr)};
      ADC_SDAT   = adc_word[15];
    end
    if (ADC_CS_N === 1'b0) begin
      cur_f.cslen = cur_f.cslen + 1;
      if (cur_f.falls == 0 && ADC_SCLK === 1'b1) cur_f.setup = cur_f.setup + 1;
      if (prev_sclk === 1'b1 && ADC_SCLK === 1'b0 && cur_f.falls < 16) begin
        ADC_SDAT = adc_word[15 - cur_f.falls];
        cur_f.pat[15 - cur_f.falls] = ADC_SADDR;
        cur_f.falls = cur_f.falls + 1;
        mon_falls = cur_f.falls;
        lowlen = 0;
      end
      if (ADC_SCLK === 1'b0) lowlen = lowlen + 1;
    end
    if (prev_cs === 1'b0 && prev_sclk === 1'b0 && ADC_SCLK === 1'b1) begin
      if (lowlen < cur_f.minlow) cur_f.minlow = lowlen;
      if (lowlen > cur_f.maxlow) cur_f.maxlow = lowlen;
      if (cur_f.falls >= 3 && cur_f.falls <= 5) addr_sh = {addr_sh[1:0], ADC_SADDR};
    end
    if (prev_cs === 1'b0 && ADC_CS_N === 1'b1) begin
      frames_done = frames_done + 1;
      if (cur_f.falls == 16) data_addr = addr_sh;
      frames.push_back(cur_f);
    end
    if (ADC_CS_N === 1'b1 && ADC_SCLK !== 1'b1) sclk_bad = sclk_bad + 1;
    prev_cs   = ADC_CS_N;
    prev_sclk = ADC_SCLK;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int target, budget;
    target = frames_done + n;
    budget = n * 100 + 200;
    while (frames_done < target && budget > 0) begin
      step();
      budget--;
    end
    if (frames_done < target) chk("frame_timeout", frames_done, target);
    repeat (4) step();
  endtask

  task automatic wait_cs_low();
    int budget;
    budget = 200;
    while (ADC_CS_N !== 1'b0 && budget > 0) begin
      step();
      budget--;
    end
    if (ADC_CS_N !== 1'b0) chk("cs_low_timeout", ADC_CS_N, 0);
  endtask

  task automatic wait_bit(input int k);
    int budget;
    budget = 200;
    while (!(mon_falls == k + 1 && ADC_CS_N === 1'b0) && budget > 0) begin
      step();
      budget--;
    end
    if (mon_falls != k + 1) chk("bit_timeout", mon_falls, k + 1);
  endtask

  task automatic check_frames();
    frame_t  f;
    strobe_t s;
    int      e;
    while (frames.size() > 0) begin
      f = frames.pop_front();
      if (f.falls != 16) begin
        // Frame cut short by reset: model restarts from its reset state.
        m_cur = 7;
        for (int i = 0; i < 8; i++) m_bank[i] = '0;
        continue;
      end
      e = nextch(m_cur, f.mask);
      chk("saddr_pattern", f.pat, 32'(e) << 11);
      chk("cs_low_cycles", f.cslen, 66);
      chk("sclk_high_before_first_fall", f.setup, 4);
      chk("sclk_low_min", f.minlow, ClkDiv);
      chk("sclk_low_max", f.maxlow, ClkDiv);
      if (!f.fresh) begin
        if (strobes.size() == 0) begin
          chk("strobe_count", strobes.size(), 1);
        end else begin
          s = strobes.pop_front();
          chk("strobe_ch", s.ch, m_prev);
          chk("strobe_data", s.val, exp_val(3'(m_prev)));
          m_bank[m_prev] = exp_val(3'(m_prev));
        end
      end
      m_prev = e;
      m_cur  = e;
    end
    chk("unexpected_strobes", strobes.size(), 0);
  endtask

  task automatic check_bank();
    for (int i = 0; i < 8; i++) begin
      rd_ch = 3'(i);
      #1;
      chk("rd_data", rd_data, m_bank[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    for (int i = 0; i < 8; i++) m_bank[i] = '0;

    // Reset values
    repeat (3) step();
    chk("rst_cs_n", ADC_CS_N, 1);
    chk("rst_sclk", ADC_SCLK, 1);
    chk("rst_saddr", ADC_SADDR, 0);
    chk("rst_sample", sample, 0);
    chk("rst_sample_ch", sample_ch, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    check_bank();

    // Alternating channels 0 and 2
    reset = 1'b0;
    fresh_req++;
    ch_mask = 8'h05;
    enable = 1'b1;
    step();
    chk("first_frame_cs_low", ADC_CS_N, 0);
    chk("first_frame_busy", busy, 1);
    chk("first_frame_no_strobe", sample_valid, 0);
    wait_frames(4);
    if (strobes.size() >= 2) chk("strobe_gap", strobes[1].cyc - strobes[0].cyc, 69);
    else chk("strobe_count_pair", strobes.size(), 2);
    check_frames();
    check_bank();

    // Empty mask: no frames while enabled
    wait_cs_low();
    ch_mask = 8'h00;
    fresh_req++;
    wait_frames(1);
    check_frames();
    n0 = starts;
    for (int i = 0; i < 4; i++) begin
      repeat (20) step();
      chk("mask0_cs_n", ADC_CS_N, 1);
      chk("mask0_busy", busy, 0);
    end
    chk("mask0_no_frame_start", starts, n0);
    chk("mask0_no_strobe", strobes.size(), 0);

    // Single-bit mask on channel 7
    ch_mask = 8'h80;
    wait_frames(3);
    check_frames();

    // Drop enable mid-frame; frame completes and delivers its sample
    wait_bit(8);
    enable = 1'b0;
    fresh_req++;
    wait_frames(1);
    repeat (40) step();
    chk("disabled_busy", busy, 0);
    chk("disabled_cs_n", ADC_CS_N, 1);
    check_frames();
    ch_mask = 8'h24;
    enable = 1'b1;
    wait_frames(3);
    check_frames();
    check_bank();

    // One-cycle reset in the middle of bit 10
    wait_bit(10);
    reset = 1'b1;
    fresh_req++;
    step();
    chk("midrst_cs_n", ADC_CS_N, 1);
    chk("midrst_sclk", ADC_SCLK, 1);
    reset = 1'b0;
    check_frames();
    check_bank();
    wait_frames(3);
    check_frames();

    // Mask change mid-frame from ch0 to ch1
    wait_cs_low();
    ch_mask = 8'h01;
    wait_frames(2);
    wait_cs_low();
    ch_mask = 8'h02;
    wait_frames(3);
    check_frames();
    check_bank();

    // Random masks, always changed inside a frame
    for (int r = 0; r < 6; r++) begin
      wait_cs_low();
      ch_mask = 8'($urandom_range(1, 255));
      wait_frames(int'($urandom_range(1, 3)));
    end
    check_frames();
    check_bank();

    chk("sclk_high_outside_frames", sclk_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
